led_pattern_sequencer: RTL and testbench



---
 rtl/led_seq_pkg.sv | 32 +++
 rtl/led_prescaler.sv | 31 +++
 rtl/led_pattern_sequencer.sv | 100 ++++++++++
 tb/tb_led_pattern_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer: mode encoding and
// the per-mode seed vector that is loaded whenever the mode changes.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_ALT   = 2'd2,
        MODE_CHASE = 2'd3
    } mode_t;

    // Upper bound on channel count supported by seed(); callers truncate.
    localparam int MAX_CHANNELS = 64;

    // Bit 0 is channel 0. Bits at or above channels are always zero.
    function automatic logic [MAX_CHANNELS-1:0] seed(input mode_t mode, input int channels);
        logic [MAX_CHANNELS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (i < channels) begin
                case (mode)
                    MODE_BLINK: v[i] = 1'b1;
                    MODE_ALT:   v[i] = ((i % 2) == 0);
                    MODE_CHASE: v[i] = (i == 0);
                    default:    v[i] = 1'b0;
                endcase
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running divider: tick is high while the low (DIV_WIDTH-RATE) counter
// bits are all ones, giving a period of 2^(DIV_WIDTH-RATE) clock cycles.
module led_prescaler #(
    parameter int DIV_WIDTH = 20
) (
    input  logic       CLOCK,
    input  logic       RESETn,
    input  logic       clear,
    input  logic [1:0] RATE,
    output logic       tick
);

    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] mask;

    // Changing RATE only changes which bits are compared, so the count is
    // never disturbed and a rate change cannot produce a double tick.
    assign mask = {DIV_WIDTH{1'b1}} >> RATE;
    assign tick = ((count & mask) == mask);

    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Active-low LED pattern generator: synchronised pin controls, a prescaled
// tick, a pattern register advanced per mode, and a gated output register.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int DIV_WIDTH = 20,
    parameter int CHANNELS  = 4
) (
    input  logic                CLOCK,
    input  logic                RESETn,
    input  logic [1:0]          MODE,
    input  logic [1:0]          RATE,
    input  logic                GATE,
    input  logic                PAUSE,
    output logic [CHANNELS-1:0] LEDn,
    output logic                TICK
);

    logic [1:0]          mode_m, mode_s;
    logic [1:0]          rate_m, rate_s;
    logic                gate_m, gate_s;
    logic                pause_m, pause_s;
    mode_t               mode_q;
    logic [CHANNELS-1:0] pattern;
    logic [CHANNELS-1:0] next_pattern;
    logic [CHANNELS-1:0] seed_vec;
    logic                tick_raw;
    logic                mode_change;

    // All four control pins are asynchronous to CLOCK.
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            mode_m  <= '0;
            mode_s  <= '0;
            rate_m  <= '0;
            rate_s  <= '0;
            gate_m  <= 1'b0;
            gate_s  <= 1'b0;
            pause_m <= 1'b0;
            pause_s <= 1'b0;
        end else begin
            mode_m  <= MODE;
            mode_s  <= mode_m;
            rate_m  <= RATE;
            rate_s  <= rate_m;
            gate_m  <= GATE;
            gate_s  <= gate_m;
            pause_m <= PAUSE;
            pause_s <= pause_m;
        end
    end

    assign mode_change = (mode_s != mode_q);
    assign seed_vec    = CHANNELS'(seed(mode_t'(mode_s), CHANNELS));

    led_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .CLOCK  (CLOCK),
        .RESETn (RESETn),
        .clear  (mode_change),
        .RATE   (rate_s),
        .tick   (tick_raw)
    );

    always_comb begin
        next_pattern = pattern;
        case (mode_q)
            MODE_OFF:   next_pattern = '0;
            MODE_BLINK: next_pattern = ~pattern;
            MODE_ALT:   next_pattern = ~pattern;
            MODE_CHASE: next_pattern = {pattern[CHANNELS-2:0], pattern[CHANNELS-1]};
            default:    next_pattern = pattern;
        endcase
    end

    // A mode change wins over a coincident tick: the fresh seed is loaded and
    // the prescaler restarts, so the first advance is a full period later.
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            mode_q  <= MODE_OFF;
            pattern <= '0;
            TICK    <= 1'b0;
            LEDn    <= '1;
        end else begin
            if (mode_change) begin
                mode_q  <= mode_t'(mode_s);
                pattern <= seed_vec;
                TICK    <= 1'b0;
            end else if (tick_raw && !pause_s) begin
                pattern <= next_pattern;
                TICK    <= 1'b1;
            end else begin
                TICK    <= 1'b0;
            end
            LEDn <= ~(pattern & {CHANNELS{~gate_s}});
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer (DIV_WIDTH=4, CHANNELS=4) against a
// tick-count based reference model of the LED patterns.
module tb_led_pattern_sequencer;

    localparam int DW = 4;
    localparam int CH = 4;

    logic          CLOCK  = 1'b0;
    logic          RESETn = 1'b0;
    logic [1:0]    MODE   = 2'd0;
    logic [1:0]    RATE   = 2'd0;
    logic          GATE   = 1'b0;
    logic          PAUSE  = 1'b0;
    logic [CH-1:0] LEDn;
    logic          TICK;

    int vectors     = 0;
    int miscompares = 0;

    led_pattern_sequencer #(.DIV_WIDTH(DW), .CHANNELS(CH)) dut (
        .CLOCK  (CLOCK),
        .RESETn (RESETn),
        .MODE   (MODE),
        .RATE   (RATE),
        .GATE   (GATE),
        .PAUSE  (PAUSE),
        .LEDn   (LEDn),
        .TICK   (TICK)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model: pins delayed two edges, then the pattern is a function
    // of the active mode and the number of advances since the last reload.
    logic [1:0]    m1, m2, r1, r2, md;
    logic          g1, g2, p1, p2;
    int            cnt, adv;
    logic [CH-1:0] exp_led;
    logic          exp_tick;

    function automatic logic [CH-1:0] pat(input logic [1:0] m, input int a);
        logic [CH-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) begin
            case (m)
                2'd1:    v[i] = ((a % 2) == 0);
                2'd2:    v[i] = (((i % 2) == 0) != ((a % 2) == 1));
                2'd3:    v[i] = (i == (a % CH));
                default: v[i] = 1'b0;
            endcase
        end
        return v;
    endfunction

    task automatic model_reset();
        m1 = 0; m2 = 0; r1 = 0; r2 = 0; md = 0;
        g1 = 0; g2 = 0; p1 = 0; p2 = 0;
        cnt = 0; adv = 0;
        exp_led = '1; exp_tick = 1'b0;
    endtask

    task automatic model_edge();
        int per;
        logic [CH-1:0] led_next;
        per = 1 << (DW - int'(r2));
        led_next = ~(pat(md, adv) & {CH{~g2}});
        if (m2 != md) begin
            md = m2; adv = 0; cnt = 0; exp_tick = 1'b0;
        end else begin
            if ((cnt % per) == per - 1 && !p2) begin
                adv++; exp_tick = 1'b1;
            end else begin
                exp_tick = 1'b0;
            end
            cnt = (cnt + 1) % (1 << DW);
        end
        exp_led = led_next;
        m2 = m1; m1 = MODE; r2 = r1; r1 = RATE;
        g2 = g1; g1 = GATE; p2 = p1; p1 = PAUSE;
    endtask

    task automatic step();
        @(posedge CLOCK);
        model_edge();
        @(negedge CLOCK);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLOCK);
        vectors++;
        if (LEDn !== 4'b1111 || TICK !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state LEDn=%b TICK=%b expected LEDn=1111 TICK=0", LEDn, TICK);
        end
        RESETn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if (LEDn !== exp_led || TICK !== exp_tick) begin
                miscompares++;
                $display("FAIL reset_off cyc%0d LEDn=%b TICK=%b expected LEDn=%b TICK=%b", i, LEDn, TICK, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_chase();
        MODE = 2'd3;
        repeat (4) step();
        vectors++;
        if (LEDn !== 4'b1110) begin
            miscompares++;
            $display("FAIL chase_seed LEDn=%b expected 1110", LEDn);
        end
        for (int i = 0; i < 80; i++) begin
            step();
            vectors++;
            if (LEDn !== exp_led || TICK !== exp_tick) begin
                miscompares++;
                $display("FAIL chase cyc%0d LEDn=%b TICK=%b expected LEDn=%b TICK=%b", i, LEDn, TICK, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_alt_blink();
        MODE = 2'd2;
        repeat (4) step();
        vectors++;
        if (LEDn !== 4'b1010) begin
            miscompares++;
            $display("FAIL alt_seed LEDn=%b expected 1010", LEDn);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            vectors++;
            if (LEDn !== exp_led || TICK !== exp_tick) begin
                miscompares++;
                $display("FAIL alt cyc%0d LEDn=%b TICK=%b expected LEDn=%b TICK=%b", i, LEDn, TICK, exp_led, exp_tick);
            end
        end
        MODE = 2'd1;
        repeat (4) step();
        vectors++;
        if (LEDn !== 4'b0000) begin
            miscompares++;
            $display("FAIL blink_seed LEDn=%b expected 0000", LEDn);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            vectors++;
            if (LEDn !== exp_led || TICK !== exp_tick) begin
                miscompares++;
                $display("FAIL blink cyc%0d LEDn=%b TICK=%b expected LEDn=%b TICK=%b", i, LEDn, TICK, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_gate();
        MODE = 2'd3;
        repeat (24) step();
        GATE = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            vectors++;
            if (LEDn !== exp_led || TICK !== exp_tick || (i >= 2 && LEDn !== 4'b1111)) begin
                miscompares++;
                $display("FAIL gate cyc%0d LEDn=%b TICK=%b expected LEDn=%b TICK=%b", i, LEDn, TICK, exp_led, exp_tick);
            end
        end
        GATE = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            vectors++;
            if (LEDn !== exp_led || TICK !== exp_tick) begin
                miscompares++;
                $display("FAIL ungate cyc%0d LEDn=%b TICK=%b expected LEDn=%b TICK=%b", i, LEDn, TICK, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_pause();
        PAUSE = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            vectors++;
            if (LEDn !== exp_led || TICK !== exp_tick || (i >= 2 && TICK !== 1'b0)) begin
                miscompares++;
                $display("FAIL pause cyc%0d LEDn=%b TICK=%b expected LEDn=%b TICK=%b", i, LEDn, TICK, exp_led, exp_tick);
            end
        end
        PAUSE = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            vectors++;
            if (LEDn !== exp_led || TICK !== exp_tick) begin
                miscompares++;
                $display("FAIL unpause cyc%0d LEDn=%b TICK=%b expected LEDn=%b TICK=%b", i, LEDn, TICK, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_mode_on_tick();
        int guard;
        guard = 0;
        while (cnt != 13 && guard < 40) begin
            step();
            guard++;
        end
        vectors++;
        if (cnt != 13) begin
            miscompares++;
            $display("FAIL mode_tick_align counter=%0d expected 13", cnt);
        end
        MODE = 2'd1;
        repeat (3) step();
        vectors++;
        if (TICK !== 1'b0 || TICK !== exp_tick) begin
            miscompares++;
            $display("FAIL mode_tick_no_tick TICK=%b expected 0", TICK);
        end
        step();
        vectors++;
        if (LEDn !== 4'b0000 || LEDn !== exp_led) begin
            miscompares++;
            $display("FAIL mode_tick_seed LEDn=%b expected 0000", LEDn);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if (LEDn !== exp_led || TICK !== exp_tick) begin
                miscompares++;
                $display("FAIL mode_tick cyc%0d LEDn=%b TICK=%b expected LEDn=%b TICK=%b", i, LEDn, TICK, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_rate();
        int ticks;
        logic prev;
        RATE = 2'd3;
        repeat (4) step();
        ticks = 0;
        prev = TICK;
        for (int i = 0; i < 20; i++) begin
            step();
            if (TICK === 1'b1) ticks++;
            vectors++;
            if (LEDn !== exp_led || TICK !== exp_tick || (prev === 1'b1 && TICK === 1'b1)) begin
                miscompares++;
                $display("FAIL rate3 cyc%0d LEDn=%b TICK=%b expected LEDn=%b TICK=%b", i, LEDn, TICK, exp_led, exp_tick);
            end
            prev = TICK;
        end
        vectors++;
        if (ticks != 10) begin
            miscompares++;
            $display("FAIL rate3_count ticks=%0d expected 10", ticks);
        end
    endtask

    task automatic test_reset_mid();
        RATE = 2'd0;
        MODE = 2'd3;
        repeat (30) step();
        #2 RESETn = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (LEDn !== 4'b1111 || TICK !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async LEDn=%b TICK=%b expected LEDn=1111 TICK=0", LEDn, TICK);
        end
        repeat (2) @(negedge CLOCK);
        RESETn = 1'b1;
        repeat (3) step();
        vectors++;
        if (LEDn !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset_release_dark LEDn=%b expected 1111", LEDn);
        end
        step();
        vectors++;
        if (LEDn !== 4'b1110) begin
            miscompares++;
            $display("FAIL reset_reload LEDn=%b expected 1110", LEDn);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            vectors++;
            if (LEDn !== exp_led || TICK !== exp_tick) begin
                miscompares++;
                $display("FAIL reset_mid cyc%0d LEDn=%b TICK=%b expected LEDn=%b TICK=%b", i, LEDn, TICK, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) MODE = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) RATE = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) GATE = ~GATE;
            if ($urandom_range(0, 19) == 0) PAUSE = ~PAUSE;
            step();
            vectors++;
            if (LEDn !== exp_led || TICK !== exp_tick) begin
                miscompares++;
                $display("FAIL random cyc%0d LEDn=%b TICK=%b expected LEDn=%b TICK=%b", i, LEDn, TICK, exp_led, exp_tick);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_chase();
        test_alt_blink();
        test_gate();
        test_pause();
        test_mode_on_tick();
        test_rate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
